// File: rtl/gshare_predictor.sv
// gshare_predictor
// ----------------
// Gshare conditional-branch predictor for the fetch stage. A table of
// saturating counters (PHT) is indexed by the word-aligned PC bits XORed with a
// speculative global history register (GHR). Fetch receives a same-cycle
// prediction plus a checkpoint (index and pre-branch history). Execute hands
// that checkpoint back when the branch resolves. After reset an internal walk
// writes every PHT entry to weakly not-taken, and ready stays low until the
// walk is done.
//
// Parameters:
//   PHT_IDX_BITS  log2 of the number of PHT entries
//   HIST_BITS     GHR length, 1 <= HIST_BITS <= PHT_IDX_BITS
//   CTR_BITS      counter width, >= 2
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   if_valid            fetch lookup this cycle
//   if_pc               PC of the fetched instruction
//   if_is_cond          fetched instruction is a conditional branch
//   if_is_uncond        fetched instruction is BR/BSR
//   pred_taken          combinational prediction
//   pred_idx            PHT index used, travels with the branch
//   pred_ghr            GHR before this branch, travels with the branch
//   ready               high once PHT initialisation has completed
//   ex_valid            a conditional branch resolved this cycle
//   ex_idx, ex_ghr      checkpoint returned from fetch
//   ex_taken            actual outcome
//   ex_mispredict       restore the GHR from the checkpoint (qualified by ex_valid)
module gshare_predictor #(
  parameter int PHT_IDX_BITS = 5,
  parameter int HIST_BITS    = 3,
  parameter int CTR_BITS     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_valid,
  input  logic [31:0]             if_pc,
  input  logic                    if_is_cond,
  input  logic                    if_is_uncond,
  output logic                    pred_taken,
  output logic [PHT_IDX_BITS-1:0] pred_idx,
  output logic [HIST_BITS-1:0]    pred_ghr,
  output logic                    ready,
  input  logic                    ex_valid,
  input  logic [PHT_IDX_BITS-1:0] ex_idx,
  input  logic [HIST_BITS-1:0]    ex_ghr,
  input  logic                    ex_taken,
  input  logic                    ex_mispredict
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  // Weakly not-taken: every bit set except the MSB.
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                  state;
  logic [PHT_IDX_BITS-1:0] init_ptr;
  logic [HIST_BITS-1:0]    ghr;
  logic                    ready_q;
  logic [CTR_BITS-1:0]     pht [PHT_ENTRIES];

  logic [PHT_IDX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]     ex_ctr;
  logic [CTR_BITS-1:0]     ex_ctr_next;

  // History concatenated with the new outcome. The low HIST_BITS bits are the
  // shifted history. This form also works when HIST_BITS is 1.
  logic [HIST_BITS:0]      spec_shift;
  logic [HIST_BITS:0]      recov_shift;

  // Bits that are deliberately not used: the PC bits outside the index, and the
  // history bits that are shifted out.
  logic                    unused_bits;

  assign lookup_idx  = if_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr);
  assign pred_idx    = lookup_idx;
  assign pred_ghr    = ghr;
  assign ready       = ready_q;
  assign spec_shift  = {ghr, pred_taken};
  assign recov_shift = {ex_ghr, ex_taken};
  assign unused_bits = ^{if_pc[31:PHT_IDX_BITS+2], if_pc[1:0],
                         spec_shift[HIST_BITS], recov_shift[HIST_BITS]};

  // Prediction. Unconditional branches are always taken. A conditional branch
  // uses the MSB of its counter, but only after the table has been initialised.
  always_comb begin
    pred_taken = 1'b0;
    if (if_is_uncond) begin
      pred_taken = 1'b1;
    end else if (if_is_cond && ready_q) begin
      pred_taken = pht[lookup_idx][CTR_BITS-1];
    end
  end

  // Saturating update of the counter selected by the returned checkpoint.
  always_comb begin
    ex_ctr      = pht[ex_idx];
    ex_ctr_next = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != CTR_MAX) begin
        ex_ctr_next = ex_ctr + CTR_BITS'(1);
      end
    end else if (ex_ctr != '0) begin
      ex_ctr_next = ex_ctr - CTR_BITS'(1);
    end
  end

  // Control FSM and speculative history.
  // In INIT, the walk advances one entry per cycle and the GHR holds at 0.
  // In READY, a mispredict restores the GHR from the checkpoint, and that
  // restore wins over a same-cycle speculative shift from fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + PHT_IDX_BITS'(1);
          if (&init_ptr) begin
            state   <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          if (ex_valid && ex_mispredict) begin
            ghr <= recov_shift[HIST_BITS-1:0];
          end else if (if_valid && if_is_cond) begin
            ghr <= spec_shift[HIST_BITS-1:0];
          end
        end
        default: begin
          state   <= S_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // PHT storage. The table has no reset of its own, because the init walk
  // rewrites every entry. An ex_* update that arrives in a reset cycle or
  // during the walk is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == S_INIT) begin
        pht[init_ptr] <= CTR_INIT;
      end else if (ex_valid) begin
        pht[ex_idx] <= ex_ctr_next;
      end
    end
  end

endmodule
